// File: rtl/prim_hardened_cnt_pkg.sv
// prim_hardened_cnt_pkg: shared op encoding and saturating arithmetic for the hardened counter.
package prim_hardened_cnt_pkg;

  typedef enum logic [2:0] {
    CntHold,
    CntClr,
    CntSet,
    CntIncr,
    CntDecr
  } cnt_op_e;

  localparam int unsigned MaxWidth = 32;

  // a + b clamped to 2^w-1; the extra MSB holds the carry for w == MaxWidth
  function automatic logic [MaxWidth-1:0] sat_add(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b,
                                                  input int unsigned w);
    logic [MaxWidth:0] sum, lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MaxWidth+1)'(1) << w) - (MaxWidth+1)'(1);
    return (sum > lim) ? lim[MaxWidth-1:0] : sum[MaxWidth-1:0];
  endfunction

  // a - b clamped to 0; the borrow lands in the extra MSB
  function automatic logic [MaxWidth-1:0] sat_sub(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b);
    logic [MaxWidth:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[MaxWidth] ? '0 : diff[MaxWidth-1:0];
  endfunction

endpackage

// File: rtl/prim_hardened_cnt_chk.sv
// prim_hardened_cnt_chk: combinational primary/shadow consistency check (XNOR + OR-reduce).
module prim_hardened_cnt_chk #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] cnt,
  input  logic [Width-1:0] cnt_shadow,
  output logic             mis
);
  assign mis = |(~(cnt ^ cnt_shadow));
endmodule

// File: rtl/prim_hardened_cnt.sv
// prim_hardened_cnt: saturating up/down counter with inverted shadow copy and registered mismatch flag.
// Define PRIM_HARDENED_CNT_STICKY_ERR_EN to make err_o latch until reset.
module prim_hardened_cnt
  import prim_hardened_cnt_pkg::*;
#(
  parameter int              Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic             sat_o,
  output logic             err_o
);

  cnt_op_e          op;
  logic [Width-1:0] cnt_q, cnt_d, cnt_shadow_q, shadow_d;
  logic             dir_q, dir_d, err_q, err_d, mis;

  assign op = clr_i                    ? CntClr  :
              set_i                    ? CntSet  :
              (incr_en_i && !decr_en_i) ? CntIncr :
              (decr_en_i && !incr_en_i) ? CntDecr : CntHold;

  assign cnt_d = (op == CntClr)  ? ResetValue :
                 (op == CntSet)  ? set_cnt_i  :
                 (op == CntIncr) ? Width'(sat_add(MaxWidth'(cnt_q), MaxWidth'(step_i), Width)) :
                 (op == CntDecr) ? Width'(sat_sub(MaxWidth'(cnt_q), MaxWidth'(step_i))) : cnt_q;

  // shadow moves opposite to the primary, computed from its own register only
  assign shadow_d = (op == CntClr)  ? ~ResetValue :
                    (op == CntSet)  ? ~set_cnt_i  :
                    (op == CntIncr) ? Width'(sat_sub(MaxWidth'(cnt_shadow_q), MaxWidth'(step_i))) :
                    (op == CntDecr) ? Width'(sat_add(MaxWidth'(cnt_shadow_q), MaxWidth'(step_i), Width)) :
                    cnt_shadow_q;

  assign dir_d = (op == CntIncr) ? 1'b1 : (op == CntDecr) ? 1'b0 : dir_q;

  prim_hardened_cnt_chk #(.Width(Width)) u_chk (
    .cnt        (cnt_q),
    .cnt_shadow (cnt_shadow_q),
    .mis        (mis)
  );

`ifdef PRIM_HARDENED_CNT_STICKY_ERR_EN
  assign err_d = err_q | mis;
`else
  assign err_d = mis;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= ResetValue;
      cnt_shadow_q <= ~ResetValue;
      dir_q        <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cnt_shadow_q <= shadow_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = dir_q ? &cnt_q : ~|cnt_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_prim_hardened_cnt.sv
// tb_prim_hardened_cnt: model-checked directed test of prim_hardened_cnt (Width=8, ResetValue=8'h05).
module tb_prim_hardened_cnt;

`ifdef PRIM_HARDENED_CNT_STICKY_ERR_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       clr_i = 1'b0, set_i = 1'b0, incr_en_i = 1'b0, decr_en_i = 1'b0;
  logic [7:0] set_cnt_i = '0, step_i = '0;
  logic [7:0] cnt_o;
  logic       sat_o, err_o;

  int n_cmp = 0, n_bad = 0;
  int m_cnt = 5;
  bit m_dir = 1'b1;
  bit run = 1'b0, skip = 1'b0, exp_err = 1'b0;
  logic [7:0] sh;

  prim_hardened_cnt #(.Width(8), .ResetValue(8'h05)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .set_i(set_i), .set_cnt_i(set_cnt_i),
    .incr_en_i(incr_en_i), .decr_en_i(decr_en_i), .step_i(step_i),
    .cnt_o(cnt_o), .sat_o(sat_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: plain integer arithmetic on the requested operation
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt <= 5;
      m_dir <= 1'b1;
    end else if (clr_i) m_cnt <= 5;
    else if (set_i) m_cnt <= int'(set_cnt_i);
    else if (incr_en_i && !decr_en_i) begin
      m_cnt <= (m_cnt + int'(step_i) > 255) ? 255 : m_cnt + int'(step_i);
      m_dir <= 1'b1;
    end else if (decr_en_i && !incr_en_i) begin
      m_cnt <= (m_cnt - int'(step_i) < 0) ? 0 : m_cnt - int'(step_i);
      m_dir <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (run) begin
      check("cnt", int'(cnt_o), m_cnt);
      check("sat", int'(sat_o), m_dir ? int'(m_cnt == 255) : int'(m_cnt == 0));
      if (!skip) begin
        check("shadow", int'(dut.cnt_shadow_q), 255 - m_cnt);
        check("err", int'(err_o), int'(exp_err));
      end
    end
  end

  task automatic drive(input bit c, input bit s, input logic [7:0] sv,
                       input bit i, input bit d, input logic [7:0] st);
    clr_i = c; set_i = s; set_cnt_i = sv; incr_en_i = i; decr_en_i = d; step_i = st;
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  initial begin
    #12;
    check("rst_cnt", int'(cnt_o), 8'h05);
    check("rst_shadow", int'(dut.cnt_shadow_q), 8'hFA);
    check("rst_err", int'(err_o), 0);
    check("rst_sat", int'(sat_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run = 1'b1;

    drive(0, 1, 8'hFD, 0, 0, 8'h00);
    drive(0, 0, 8'h00, 1, 0, 8'h04);
    check("incr_sat_cnt", int'(cnt_o), 8'hFF);
    check("incr_sat_sat", int'(sat_o), 1);
    check("incr_sat_shadow", int'(dut.cnt_shadow_q), 8'h00);
    check("incr_sat_err", int'(err_o), 0);
    drive(0, 0, 8'h00, 1, 0, 8'h04);
    check("incr_hold_ff", int'(cnt_o), 8'hFF);

    drive(0, 1, 8'h03, 0, 0, 8'h00);
    drive(0, 0, 8'h00, 0, 1, 8'h05);
    check("decr_sat_cnt", int'(cnt_o), 8'h00);
    check("decr_sat_sat", int'(sat_o), 1);
    drive(0, 1, 8'h40, 1, 0, 8'h01);
    check("set_wins_cnt", int'(cnt_o), 8'h40);
    check("set_wins_shadow", int'(dut.cnt_shadow_q), 8'hBF);

    drive(0, 1, 8'h20, 0, 0, 8'h00);
    drive(0, 0, 8'h00, 1, 1, 8'h03);
    check("both_hold", int'(cnt_o), 8'h20);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    drive(0, 0, 8'h00, 1, 1, 8'h03);
    check("both_dir_kept", int'(sat_o), 1);
    drive(1, 1, 8'h77, 0, 0, 8'h00);
    check("clr_wins", int'(cnt_o), 8'h05);

    drive(0, 0, 8'h00, 1, 0, 8'h0A);
    drive(0, 0, 8'h00, 0, 1, 8'h03);
    drive(0, 0, 8'h00, 1, 0, 8'h00);
    drive(0, 0, 8'h00, 1, 0, 8'hF0);
    drive(0, 0, 8'h00, 0, 1, 8'h00);
    drive(0, 0, 8'h00, 0, 1, 8'hC8);
    drive(0, 0, 8'h00, 0, 1, 8'h80);
    drive(0, 0, 8'h00, 1, 0, 8'h7F);
    drive(0, 1, 8'hFF, 1, 0, 8'h00);
    drive(0, 0, 8'h00, 1, 0, 8'h00);
    check("step0_ff_sat", int'(sat_o), 1);
    idle();

    sh = dut.cnt_shadow_q;
    skip = 1'b1;
    force dut.cnt_shadow_q = sh ^ 8'h08;
    #1 check("err_before_edge", int'(err_o), 0);
    @(negedge clk_i);
    check("err_one_edge", int'(err_o), 1);
    release dut.cnt_shadow_q;
    drive(1, 0, 8'h00, 0, 0, 8'h00);
    idle();
    check("err_after_clr", int'(err_o), int'(Sticky));
    exp_err = Sticky;
    skip = 1'b0;
    idle();

    drive(0, 1, 8'h7E, 0, 0, 8'h00);
    sh = dut.cnt_shadow_q;
    skip = 1'b1;
    force dut.cnt_shadow_q = sh ^ 8'h08;
    @(negedge clk_i);
    check("err_pre_rst", int'(err_o), 1);
    release dut.cnt_shadow_q;
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_cnt", int'(cnt_o), 8'h05);
    check("async_rst_shadow", int'(dut.cnt_shadow_q), 8'hFA);
    check("async_rst_err", int'(err_o), 0);
    check("async_rst_sat", int'(sat_o), 0);
    exp_err = 1'b0;
    skip = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 8'h00, 1, 0, 8'h11);
    check("post_rst_incr", int'(cnt_o), 8'h16);
    drive(0, 0, 8'h00, 0, 1, 8'h06);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
